sprite_row_fetcher: RTL
=======================

Name: sprite_row_fetcher

Overview:
- Downstream consumer of the sprite/graphics RAM, which has 1-cycle registered read latency.
- On a start pulse, reads WORDS_PER_ROW consecutive words beginning at row_addr.
- Unpacks each word into PIX_BITS-wide pixels and streams them to the pixel/colour stage over a valid/ready handshake.
- Drives the RAM read port directly; never writes RAM.

Parameters:
- WORD_SIZE, 32, RAM word width; must be a multiple of PIX_BITS.
- ADDR_BITS, 4, RAM address width.
- PIX_BITS, 2, bits per pixel; PIX_PER_WORD = WORD_SIZE/PIX_BITS (16 at defaults).
- WORDS_PER_ROW, 2, words fetched per row; range 1..2**ADDR_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to fetch and stream a row
- row_addr  in  ADDR_BITS  first word address; sampled with start
- busy  out  1  high from the cycle after start is accepted until the last pixel is accepted
- mem_addr  out  ADDR_BITS  RAM read address (registered)
- mem_we  out  1  RAM write enable; tied 0
- mem_data  in  WORD_SIZE  RAM read data; valid the cycle after mem_addr is presented
- pix_valid  out  1  pix_data is valid
- pix_ready  in  1  downstream accepts the pixel when pix_valid and pix_ready are both high
- pix_data  out  PIX_BITS  current pixel
- pix_last  out  1  high with the final pixel of the row

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, mem_addr=0, mem_we=0, pix_valid=0, pix_data=0, pix_last=0; word and pixel counters 0.
- IDLE:
  - start=1 latches row_addr and goes to ISSUE.
  - start while busy is ignored, with no effect on the current row.
- ISSUE (1 cycle): mem_addr = row_addr + word_idx, modulo 2**ADDR_BITS (wraps 0xF -> 0x0); go to CAPTURE.
- CAPTURE (1 cycle): at the end of the cycle, shifter <= mem_data and pixel counter <= 0; go to STREAM.
- STREAM:
  - pix_valid=1, pix_data = shifter[PIX_BITS-1:0] (pixel 0 is the LSBs).
  - On each handshake: shifter >>= PIX_BITS, pixel counter += 1.
  - pix_valid with pix_ready=0: pix_data and pix_last hold stable and the state holds.
  - On acceptance of pixel PIX_PER_WORD-1: if word_idx < WORDS_PER_ROW-1, then word_idx += 1 and go to ISSUE; otherwise go to IDLE with busy=0 and pix_valid=0 the next cycle.
- pix_last = 1 only during the last pixel of the last word.
- Latency:
  - start sampled at edge 0 -> first pix_valid in cycle 3.
  - Without prefetch, a 2-cycle pix_valid bubble occurs between words.
- start in the same cycle the last pixel is accepted: ignored (busy still 1); the requester re-asserts start after busy falls.
- Reset asserted mid-row: immediate return to the reset values; the partial row is discarded and no pixel is delivered after the reset.
- Register widths: word_idx is ADDR_BITS+1 bits; the pixel counter is clog2(PIX_PER_WORD) bits.

Optional Feature:
- Macro: SPRITE_ROW_FETCHER_PREFETCH_EN.
- Enabled:
  - While streaming word k (k < WORDS_PER_ROW-1), the next word's read is issued in the first STREAM cycle.
  - That word is captured into a holding register the following cycle.
  - On the final-pixel handshake, the shifter loads from the holding register, giving continuous pix_valid across word boundaries (no bubble).
  - First-pixel latency is unchanged (3 cycles).
- Disabled: no holding register; the ISSUE/CAPTURE bubble applies between every pair of words.

Test Plan:
- Reset value check: assert reset mid-cycle with no clock edge -> all outputs 0 immediately; mem_we is 0 throughout the test.
- Single row, mem[3]=32'h0000_00E4, mem[4]=32'hFFFF_FFFF, row_addr=3, pix_ready=1:
  - pixels 0..3 = 0,1,2,3, then 12 zeros, then 16 threes;
  - pix_last only on pixel 31;
  - first pix_valid 3 cycles after start;
  - busy falls after pixel 31.
- Wrap-around: row_addr=4'hF -> mem_addr sequence F then 0.
- Backpressure: pix_ready toggled 1,0,0,1 -> pix_data stable during the low cycles; no pixel lost or duplicated (compare against the reference model).
- Ignored start / reset mid-row:
  - start pulsed at pixel 5 -> the row continues unchanged and no extra fetch occurs;
  - reset at pixel 10 -> pix_valid=0 at once, and a new start fetches cleanly.
- PREFETCH_EN build, pix_ready=1 -> pix_valid high for 32 consecutive cycles; the non-PREFETCH build shows a 2-cycle gap after pixel 15.

Source files
------------

// File: rtl/sprite_row_fetcher.sv
// sprite_row_fetcher
//   Reads WORDS_PER_ROW consecutive words from the sprite RAM, starting at
//   row_addr, and streams each word out as PIX_BITS-wide pixels over a
//   valid/ready handshake. Pixel 0 of a word is its least significant bits.
//   The RAM has a 1-cycle registered read: data for the address presented in
//   cycle n appears on mem_data in cycle n+1.
//
//   Optional build macro SPRITE_ROW_FETCHER_PREFETCH_EN: fetches the next word
//   into a holding register while the current word streams, which removes the
//   2-cycle pix_valid bubble between words. It needs PIX_PER_WORD >= 2.
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high reset
//   start      one-cycle request to fetch and stream a row (ignored while busy)
//   row_addr   first word address, sampled with start
//   busy       high from the cycle after start until the last pixel is accepted
//   mem_addr   registered RAM read address
//   mem_we     RAM write enable, always 0
//   mem_data   RAM read data
//   pix_valid  pix_data is valid
//   pix_ready  downstream accepts the pixel when pix_valid && pix_ready
//   pix_data   current pixel
//   pix_last   final pixel of the row
module sprite_row_fetcher #(
  parameter int WORD_SIZE     = 32,
  parameter int ADDR_BITS     = 4,
  parameter int PIX_BITS      = 2,
  parameter int WORDS_PER_ROW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] row_addr,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [PIX_BITS-1:0]  pix_data,
  output logic                 pix_last
);

  localparam int PIX_PER_WORD = WORD_SIZE / PIX_BITS;
  localparam int CNT_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [CNT_W-1:0]   LAST_PIX  = CNT_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_BITS:0] LAST_WORD = (ADDR_BITS + 1)'(WORDS_PER_ROW - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, STREAM} state_t;

  state_t                 state, state_next;
  logic [ADDR_BITS-1:0]   row_base;
  logic [ADDR_BITS:0]     word_idx;
  logic [CNT_W-1:0]       pix_cnt;
  logic [WORD_SIZE-1:0]   shifter;
  logic                   handshake, word_done, row_done;

`ifdef SPRITE_ROW_FETCHER_PREFETCH_EN
  logic [WORD_SIZE-1:0]   hold;
  logic                   issued;   // prefetch address is on mem_addr this cycle
  logic                   cap;      // prefetched word is on mem_data this cycle
`endif

  assign mem_we    = 1'b0;
  assign pix_data  = shifter[PIX_BITS-1:0];
  assign handshake = pix_valid && pix_ready;
  assign word_done = handshake && (pix_cnt == LAST_PIX);
  assign row_done  = word_done && (word_idx == LAST_WORD);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  // NOTE: default assignment first so no path leaves state_next unassigned
  // (which would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = STREAM;
      STREAM: begin
        if (row_done) begin
          state_next = IDLE;
        end else if (word_done) begin
`ifdef SPRITE_ROW_FETCHER_PREFETCH_EN
          state_next = STREAM;   // next word is already in the holding register
`else
          state_next = ISSUE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state != IDLE);
    pix_valid = (state == STREAM);
    pix_last  = (state == STREAM) && (word_idx == LAST_WORD) && (pix_cnt == LAST_PIX);
  end

  // Datapath: address generation, word capture and pixel shifting.
  // mem_addr is loaded on the edge that enters ISSUE so the RAM sees it
  // during ISSUE and returns the word during CAPTURE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base <= '0;
      word_idx <= '0;
      pix_cnt  <= '0;
      shifter  <= '0;
      mem_addr <= '0;
`ifdef SPRITE_ROW_FETCHER_PREFETCH_EN
      hold     <= '0;
      issued   <= 1'b0;
      cap      <= 1'b0;
`endif
    end else begin
`ifdef SPRITE_ROW_FETCHER_PREFETCH_EN
      issued <= 1'b0;
      cap    <= issued;
      if (cap) hold <= mem_data;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            row_base <= row_addr;
            word_idx <= '0;
            mem_addr <= row_addr;
          end
        end
        ISSUE: ;
        CAPTURE: begin
          shifter <= mem_data;
          pix_cnt <= '0;
`ifdef SPRITE_ROW_FETCHER_PREFETCH_EN
          // Issue the second word's read so it lands in the first STREAM cycle.
          if (word_idx != LAST_WORD) begin
            mem_addr <= row_base + word_idx[ADDR_BITS-1:0] + ADDR_BITS'(1);
            issued   <= 1'b1;
          end
`endif
        end
        STREAM: begin
          if (handshake) begin
            shifter <= shifter >> PIX_BITS;
            pix_cnt <= pix_cnt + CNT_W'(1);
          end
          if (word_done && !row_done) begin
            word_idx <= word_idx + (ADDR_BITS + 1)'(1);
`ifdef SPRITE_ROW_FETCHER_PREFETCH_EN
            // The prefetched word may still be on mem_data if the boundary
            // arrives the very cycle it is being captured.
            shifter <= cap ? mem_data : hold;
            pix_cnt <= '0;
            if ((word_idx + (ADDR_BITS + 1)'(1)) != LAST_WORD) begin
              mem_addr <= row_base + word_idx[ADDR_BITS-1:0] + ADDR_BITS'(2);
              issued   <= 1'b1;
            end
`else
            mem_addr <= row_base + word_idx[ADDR_BITS-1:0] + ADDR_BITS'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
